// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: adder/compare/logic/shift result registered in a single valid/ready slot.
// Optional macro ALU_SERIAL_SHIFT_EN swaps the barrel shifter for a 1-bit-per-cycle serial shifter.
`ifndef ALU_ADD
`define ALU_ADD 0
`endif
`ifndef ALU_SLL
`define ALU_SLL 1
`endif
`ifndef ALU_SLT
`define ALU_SLT 2
`endif
`ifndef ALU_XOR
`define ALU_XOR 3
`endif
`ifndef ALU_SRL
`define ALU_SRL 4
`endif
`ifndef ALU_SRA
`define ALU_SRA 5
`endif
`ifndef ALU_OR
`define ALU_OR 6
`endif
`ifndef ALU_AND
`define ALU_AND 7
`endif

module alu_exec_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_TYPE = 8
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [XLEN-1:0]     i_alu_a,
  input  logic [XLEN-1:0]     i_alu_b,
  input  logic                i_alu_sub,
  input  logic                i_alu_sign,
  input  logic [ALU_TYPE-1:0] i_alu_t,
  input  logic [4:0]          i_rd,
  input  logic                i_wen,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [XLEN-1:0]     o_result,
  output logic                o_zero,
  output logic                o_less,
  output logic [4:0]          o_rd,
  output logic                o_wen
);
  localparam int unsigned SHW  = $clog2(XLEN);
  localparam int unsigned SUMW = XLEN + 1;

  logic [SUMW-1:0] w_sum;
  logic [XLEN-1:0] w_b_orig, w_rest, w_shift, w_result;
  logic [SHW-1:0]  w_shamt;
  logic            w_less, w_zero;

  logic            w_wr_en, w_wr_zero, w_wr_less, w_wr_wen;
  logic [XLEN-1:0] w_wr_result;
  logic [4:0]      w_wr_rd;

  logic            r_valid, r_zero, r_less, r_wen;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd;

  // B arrives pre-inverted for subtract, so the carry-in completes the two's complement
  assign w_sum    = {1'b0, i_alu_a} + {1'b0, i_alu_b} + SUMW'(i_alu_sub);
  assign w_b_orig = ~i_alu_b;
  assign w_zero   = (w_sum[XLEN-1:0] == '0);
  assign w_less   = i_alu_sign ?
                    ((i_alu_a[XLEN-1] ^ w_b_orig[XLEN-1]) ? i_alu_a[XLEN-1] : w_sum[XLEN-1]) :
                    ~w_sum[XLEN];
  assign w_shamt  = i_alu_b[SHW-1:0];

  assign w_rest = ({XLEN{i_alu_t[`ALU_ADD]}} & w_sum[XLEN-1:0])
                | ({XLEN{i_alu_t[`ALU_SLT]}} & XLEN'(w_less))
                | ({XLEN{i_alu_t[`ALU_XOR]}} & (i_alu_a ^ i_alu_b))
                | ({XLEN{i_alu_t[`ALU_OR]}}  & (i_alu_a | i_alu_b))
                | ({XLEN{i_alu_t[`ALU_AND]}} & (i_alu_a & i_alu_b));
  assign w_result = w_rest | w_shift;

`ifdef ALU_SERIAL_SHIFT_EN
  typedef enum logic {S_IDLE, S_SHIFT} state_e;
  typedef enum logic [1:0] {D_SLL, D_SRL, D_SRA} dir_e;

  state_e          r_state, w_state_nxt;
  dir_e            r_dir, w_dir;
  logic [XLEN-1:0] r_work, r_rest, w_work_sh;
  logic [SHW-1:0]  r_cnt;
  logic            r_zero_p, r_less_p, r_wen_p;
  logic [4:0]      r_rd_p;
  logic            w_slot_free, w_is_shift, w_accept, w_start, w_step, w_final;

  assign w_slot_free = ~r_valid | i_ready;
  assign w_is_shift  = i_alu_t[`ALU_SLL] | i_alu_t[`ALU_SRL] | i_alu_t[`ALU_SRA];
  // Only zero-amount shifts take the single-cycle path, where the result is A itself
  assign w_shift     = {XLEN{w_is_shift}} & i_alu_a;
  // One serial direction per op; multiple shift bits resolve SRA > SRL > SLL
  assign w_dir       = i_alu_t[`ALU_SRA] ? D_SRA : (i_alu_t[`ALU_SRL] ? D_SRL : D_SLL);

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = w_slot_free;
        if (i_valid && w_slot_free && w_is_shift && (w_shamt != '0)) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt != SHW'(1)) begin
          w_step = 1'b1;
        end else if (w_slot_free) begin
          w_step      = 1'b1;
          w_final     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    case (r_dir)
      D_SRL:   w_work_sh = {1'b0, r_work[XLEN-1:1]};
      D_SRA:   w_work_sh = {r_work[XLEN-1], r_work[XLEN-1:1]};
      default: w_work_sh = {r_work[XLEN-2:0], 1'b0};
    endcase
  end

  // Work register plus the op's side-band, held until the final shift lands in the slot
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_work   <= '0;
      r_rest   <= '0;
      r_cnt    <= '0;
      r_dir    <= D_SLL;
      r_zero_p <= 1'b0;
      r_less_p <= 1'b0;
      r_rd_p   <= '0;
      r_wen_p  <= 1'b0;
    end else if (w_start) begin
      r_work   <= i_alu_a;
      r_rest   <= w_rest;
      r_cnt    <= w_shamt;
      r_dir    <= w_dir;
      r_zero_p <= w_zero;
      r_less_p <= w_less;
      r_rd_p   <= i_rd;
      r_wen_p  <= i_wen;
    end else if (w_step) begin
      r_work <= w_work_sh;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

  assign w_accept    = i_valid & o_ready;
  assign w_wr_en     = (w_accept & ~w_start) | w_final;
  assign w_wr_result = w_final ? (w_work_sh | r_rest) : w_result;
  assign w_wr_zero   = w_final ? r_zero_p : w_zero;
  assign w_wr_less   = w_final ? r_less_p : w_less;
  assign w_wr_rd     = w_final ? r_rd_p   : i_rd;
  assign w_wr_wen    = w_final ? r_wen_p  : i_wen;
`else
  assign w_shift = ({XLEN{i_alu_t[`ALU_SLL]}} & (i_alu_a << w_shamt))
                 | ({XLEN{i_alu_t[`ALU_SRL]}} & (i_alu_a >> w_shamt))
                 | ({XLEN{i_alu_t[`ALU_SRA]}} & XLEN'($signed(i_alu_a) >>> w_shamt));

  assign o_ready     = ~r_valid | i_ready;
  assign w_wr_en     = i_valid & o_ready;
  assign w_wr_result = w_result;
  assign w_wr_zero   = w_zero;
  assign w_wr_less   = w_less;
  assign w_wr_rd     = i_rd;
  assign w_wr_wen    = i_wen;
`endif

  // Result slot: flush drops the op and empties the slot but keeps the payload
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_less   <= 1'b0;
      r_rd     <= '0;
      r_wen    <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_wr_en) begin
      r_valid  <= 1'b1;
      r_result <= w_wr_result;
      r_zero   <= w_wr_zero;
      r_less   <= w_wr_less;
      r_rd     <= w_wr_rd;
      r_wen    <= w_wr_wen;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_less   = r_less;
  assign o_rd     = r_rd;
  assign o_wen    = r_wen;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed literal cases plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_alu_exec_stage;
  localparam int unsigned XLEN = 32;
  localparam int ADD = 0, SLL = 1, SLT = 2, XOR = 3, SRL = 4, SRA = 5, OR_ = 6, AND_ = 7;
`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic            i_clock = 1'b0;
  logic            i_reset_n, i_flush, i_valid, i_ready, i_alu_sub, i_alu_sign, i_wen;
  logic [XLEN-1:0] i_alu_a, i_alu_b;
  logic [7:0]      i_alu_t;
  logic [4:0]      i_rd;
  logic            o_ready, o_valid, o_zero, o_less, o_wen;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_stage #(.XLEN(XLEN), .ALU_TYPE(8)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_alu_a(i_alu_a), .i_alu_b(i_alu_b), .i_alu_sub(i_alu_sub),
    .i_alu_sign(i_alu_sign), .i_alu_t(i_alu_t), .i_rd(i_rd), .i_wen(i_wen),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero),
    .o_less(o_less), .o_rd(o_rd), .o_wen(o_wen)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {zero, less, result} straight from the arithmetic definitions
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic sign, input logic [7:0] t);
    logic [63:0] s;
    logic [31:0] bo, r;
    logic        less, zero;
    int          sh;
    s    = 64'(a) + 64'(b) + 64'(sub);
    bo   = ~b;
    zero = (s[31:0] == 32'd0);
    if (sign) less = (a[31] != bo[31]) ? a[31] : s[31];
    else      less = !s[32];
    sh = int'(b[4:0]);
    r  = 32'd0;
    if (t[ADD])  r |= s[31:0];
    if (t[SLL])  r |= a << sh;
    if (t[SLT])  r |= {31'd0, less};
    if (t[XOR])  r |= a ^ b;
    if (t[SRL])  r |= a >> sh;
    if (t[SRA])  r |= 32'($signed(a) >>> sh);
    if (t[OR_])  r |= a | b;
    if (t[AND_]) r |= a & b;
    return {zero, less, r};
  endfunction

  // Model: slot contents plus, for serial shifts, the number of edges still owed
  bit          m_live = 1'b0, m_valid = 1'b0, m_zero = 1'b0, m_less = 1'b0, m_wen = 1'b0, m_busy = 1'b0;
  logic [31:0] m_res = '0, p_res = '0;
  logic [4:0]  m_rd = '0, p_rd = '0;
  bit          p_zero = 1'b0, p_less = 1'b0, p_wen = 1'b0;
  int          m_left = 0;

  always @(posedge i_clock) begin
    logic [33:0] f;
    if (!i_reset_n) begin
      m_live = 1'b1; m_valid = 1'b0; m_res = '0; m_zero = 1'b0; m_less = 1'b0;
      m_rd = '0; m_wen = 1'b0; m_busy = 1'b0;
    end else if (i_flush) begin
      m_valid = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_left > 1) begin
        m_left--;
        if (m_valid && i_ready) m_valid = 1'b0;
      end else if (!m_valid || i_ready) begin
        m_valid = 1'b1; m_res = p_res; m_zero = p_zero; m_less = p_less;
        m_rd = p_rd; m_wen = p_wen; m_busy = 1'b0;
      end
    end else if (i_valid && (!m_valid || i_ready)) begin
      f = ref_alu(i_alu_a, i_alu_b, i_alu_sub, i_alu_sign, i_alu_t);
      if (SERIAL && (i_alu_t[SLL] || i_alu_t[SRL] || i_alu_t[SRA]) && (i_alu_b[4:0] != 5'd0)) begin
        m_busy = 1'b1; m_left = int'(i_alu_b[4:0]);
        p_res = f[31:0]; p_zero = f[33]; p_less = f[32]; p_rd = i_rd; p_wen = i_wen;
        if (m_valid && i_ready) m_valid = 1'b0;
      end else begin
        m_valid = 1'b1; m_res = f[31:0]; m_zero = f[33]; m_less = f[32];
        m_rd = i_rd; m_wen = i_wen;
      end
    end else if (m_valid && i_ready) begin
      m_valid = 1'b0;
    end
  end

  // Every cycle, mid-period: DUT against the model
  always @(negedge i_clock) begin
    if (m_live) begin
      chk("valid",  32'(o_valid),  32'(m_valid));
      chk("ready",  32'(o_ready),  32'((!m_busy) && (!m_valid || i_ready)));
      chk("result", o_result,      m_res);
      chk("zero",   32'(o_zero),   32'(m_zero));
      chk("less",   32'(o_less),   32'(m_less));
      chk("rd",     32'(o_rd),     32'(m_rd));
      chk("wen",    32'(o_wen),    32'(m_wen));
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #2;
  endtask

  task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sign, input logic [7:0] t);
    i_valid = v; i_alu_a = a; i_alu_b = b; i_alu_sub = sub; i_alu_sign = sign; i_alu_t = t;
    i_rd = 5'($urandom_range(0, 31)); i_wen = 1'($urandom_range(0, 1));
  endtask

  // Issue one op, then wait (bounded) for it to appear in the slot
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic sign, input logic [7:0] t);
    set_op(1'b1, a, b, sub, sign, t);
    tick();
    i_valid = 1'b0;
    for (int n = 0; n < 40 && !o_valid; n++) tick();
    chk("issue_done", 32'(o_valid), 32'd1);
  endtask

  function automatic logic [7:0] oh(input int idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  initial begin
    i_reset_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    set_op(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, oh(ADD));
    tick(); tick();
    chk("rst_valid",  32'(o_valid), 32'd0);
    chk("rst_result", o_result,     32'd0);
    chk("rst_ready",  32'(o_ready), 32'd1);
    chk("rst_rd",     32'(o_rd),    32'd0);
    i_reset_n = 1'b1;
    issue(32'd5, 32'd7, 1'b0, 1'b0, oh(ADD));
    chk("add_5_7", o_result, 32'd12);

    issue(32'hFFFF_FFFF, ~32'd1, 1'b1, 1'b1, oh(SLT));
    chk("slt_signed", o_result, 32'd1);
    chk("slt_signed_less", 32'(o_less), 32'd1);
    issue(32'hFFFF_FFFF, ~32'd1, 1'b1, 1'b0, oh(SLT));
    chk("sltu", o_result, 32'd0);
    issue(32'h1234, ~32'h1234, 1'b1, 1'b0, oh(ADD));
    chk("beq_zero", 32'(o_zero), 32'd1);

    issue(32'h8000_0000, 32'd4, 1'b0, 1'b0, oh(SRA));
    chk("sra", o_result, 32'hF800_0000);
    issue(32'h8000_0000, 32'd4, 1'b0, 1'b0, oh(SRL));
    chk("srl", o_result, 32'h0800_0000);
    issue(32'd1, 32'h3F, 1'b0, 1'b0, oh(SLL));
    chk("sll_shamt5", o_result, 32'h8000_0000);
    issue(32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, 1'b0, oh(OR_) | oh(AND_));
    chk("multi_hot", o_result, 32'hFFF0_00FF);

    tick();
    i_ready = 1'b0;
    set_op(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, oh(ADD));
    tick();
    chk("bp_result", o_result, 32'd2);
    chk("bp_ready",  32'(o_ready), 32'd0);
    set_op(1'b1, 32'hF0, 32'hFF, 1'b0, 1'b0, oh(XOR));
    tick();
    chk("bp_hold", o_result, 32'd2);
    i_ready = 1'b1;
    tick();
    chk("bp_overwrite", o_result, 32'h0F);
    chk("bp_valid", 32'(o_valid), 32'd1);

    i_flush = 1'b1;
    set_op(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, oh(ADD));
    tick();
    chk("flush_drop", 32'(o_valid), 32'd0);
    chk("flush_keep", o_result, 32'h0F);
    i_flush = 1'b0; i_ready = 1'b0;
    set_op(1'b1, 32'd2, 32'd3, 1'b0, 1'b0, oh(ADD));
    tick();
    chk("flush_pre", o_result, 32'd5);
    i_valid = 1'b0; i_flush = 1'b1;
    tick();
    chk("flush_full", 32'(o_valid), 32'd0);
    i_flush = 1'b0; i_ready = 1'b1;

`ifdef ALU_SERIAL_SHIFT_EN
    set_op(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, oh(SLL));
    tick();
    chk("ser_busy0", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    for (int n = 1; n < 5; n++) begin
      tick();
      chk("ser_busy", 32'(o_ready), 32'd0);
      chk("ser_wait", 32'(o_valid), 32'd0);
    end
    tick();
    chk("ser_done", 32'(o_valid), 32'd1);
    chk("ser_res", o_result, 32'h60);
    set_op(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, oh(SLL));
    tick();
    i_valid = 1'b0;
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("ser_flush_idle", 32'(o_ready), 32'd1);
    for (int n = 0; n < 6; n++) tick();
    chk("ser_flush_drop", 32'(o_valid), 32'd0);
`endif

    for (int i = 0; i < 2500; i++) begin
      logic [31:0] a, bo;
      logic [7:0]  t;
      logic        sub;
      int          r;
      i_reset_n = ($urandom_range(0, 299) != 0);
      i_flush   = ($urandom_range(0, 99) < 3);
      i_ready   = ($urandom_range(0, 9) < 8);
      r = int'($urandom_range(0, 3));
      a = (r == 0) ? 32'h8000_0000 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
      r = int'($urandom_range(0, 3));
      bo = (r == 0) ? a : (r == 1) ? 32'($urandom_range(0, 63)) : $urandom;
      sub = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      if (r < 10)                t = 8'd0;
      else if (r < 25 && !SERIAL) t = 8'($urandom);
      else                       t = oh(int'($urandom_range(0, 7)));
      set_op(($urandom_range(0, 9) < 7), a, sub ? ~bo : bo, sub, 1'($urandom_range(0, 1)), t);
      tick();
    end
    i_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
